// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive (and future transmit) path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} rx_state_e;

    localparam int MAX_DATA_BITS = 9;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
        int per_tick;
        per_tick = baud * oversample;
        return (clk_freq + per_tick / 2) / per_tick;
    endfunction

    function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick_o every Div clocks, phase reset by restart.
module uart_baud_tick #(
    parameter int Div = 78
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart,
    output logic tick_o
);
    localparam int CW = (Div > 1) ? $clog2(Div) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || restart) begin
            cnt    <= '0;
            tick_o <= 1'b0;
        end else if (cnt == CW'(Div - 1)) begin
            cnt    <= '0;
            tick_o <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            tick_o <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote sampling and a ready/valid holding register.
// Optional break detection (break_o, BREAK_WAIT) is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_param import uart_pkg::*; #(
    parameter int ClockFrequency  = 12_000_000,
    parameter int DesiredBaudRate = 9_600,
    parameter int Oversample      = 16,
    parameter int DataBits        = 8,
    parameter int ParityEn        = 0,
    parameter int ParityOdd       = 0,
    parameter int StopBits        = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rx_i,
    output logic [DataBits-1:0] data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                frame_err_o,
    output logic                parity_err_o,
    output logic                overrun_o
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                break_o
`endif
);
    localparam int Div = baud_div(ClockFrequency, DesiredBaudRate, Oversample);
    localparam int SW  = $clog2(Oversample);
    localparam logic [SW-1:0] V0   = SW'(Oversample / 2 - 1);
    localparam logic [SW-1:0] V1   = SW'(Oversample / 2);
    localparam logic [SW-1:0] V2   = SW'(Oversample / 2 + 1);
    localparam logic [SW-1:0] LAST = SW'(Oversample - 1);

    rx_state_e           state;
    logic                rx_meta, rx_sync, rx_prev;
    logic                tick, vote, vote_now, bit_end;
    logic [SW-1:0]       scnt;
    logic                s0, s1;
    logic [3:0]          bcnt;
    logic [DataBits-1:0] shreg;
    logic                ferr, perr, done;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                all_zero;
`endif

    uart_baud_tick #(.Div(Div)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .restart(state == IDLE),
        .tick_o (tick)
    );

    assign vote     = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
    assign vote_now = tick && (scnt == V2);
    assign bit_end  = tick && (scnt == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            state        <= IDLE;
            scnt         <= '0;
            s0           <= 1'b0;
            s1           <= 1'b0;
            bcnt         <= '0;
            shreg        <= '0;
            ferr         <= 1'b0;
            perr         <= 1'b0;
            done         <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            break_o      <= 1'b0;
            all_zero     <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx_i;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            done      <= 1'b0;
            overrun_o <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            break_o   <= 1'b0;
`endif
            if (tick && scnt == V0) s0 <= rx_sync;
            if (tick && scnt == V1) s1 <= rx_sync;
            if (tick) scnt <= (scnt == LAST) ? '0 : scnt + 1'b1;

            case (state)
                // Only a falling edge starts a frame, so a line held low never retriggers.
                IDLE: begin
                    scnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        state <= START;
                        ferr  <= 1'b0;
                        perr  <= 1'b0;
                        bcnt  <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
                        all_zero <= 1'b1;
`endif
                    end
                end
                START: begin
                    if (vote_now && vote) state <= IDLE;
                    else if (bit_end)     state <= DATA;
                end
                DATA: begin
                    if (vote_now) shreg <= {vote, shreg[DataBits-1:1]};
                    if (bit_end) begin
                        if (bcnt == 4'(DataBits - 1)) begin
                            bcnt  <= '0;
                            state <= (ParityEn != 0) ? PARITY : STOP;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (vote_now && (vote != parity_calc(MAX_DATA_BITS'(shreg), ParityOdd != 0)))
                        perr <= 1'b1;
                    if (bit_end) state <= STOP;
                end
                // Leave at the last stop vote so a back-to-back start edge is not missed.
                STOP: begin
                    if (vote_now) begin
                        if (!vote) ferr <= 1'b1;
                        if (bcnt == 4'(StopBits - 1)) begin
`ifdef UART_RX_BREAK_DETECT_EN
                            if (all_zero && !vote) begin
                                state   <= BREAK_WAIT;
                                break_o <= 1'b1;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
`else
                            state <= IDLE;
                            done  <= 1'b1;
`endif
                        end
                    end else if (bit_end) begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    if (rx_sync) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef UART_RX_BREAK_DETECT_EN
            if (vote_now && vote && (state == DATA || state == PARITY || state == STOP))
                all_zero <= 1'b0;
`endif

            if (done) begin
                if (!valid_o || ready_i) begin
                    data_o       <= shreg;
                    frame_err_o  <= ferr;
                    parity_err_o <= perr;
                    valid_o      <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three instances (8N1, 7E1, 8N2) at a reduced clock.
module tb_uart_rx_param;
    // 1.7 MHz / (10 kBd * 16) = 10.625 -> 11 clocks per tick, 176 clocks per bit.
    localparam int CF  = 1_700_000;
    localparam int BR  = 10_000;
    localparam int BIT = 11 * 16;

    typedef struct packed {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx, rdy, vld, fe, pe, ovr, brk;
    logic [7:0] data0, data2;
    logic [6:0] data1;
    logic [8:0] dat [3];

    exp_t q0[$], q1[$], q2[$];
    int   checks = 0;
    int   errors = 0;
    int   ov_cnt [3];
    int   brk_cnt [3];

    always #5 clk = ~clk;

    assign dat[0] = {1'b0, data0};
    assign dat[1] = {2'b0, data1};
    assign dat[2] = {1'b0, data2};

    uart_rx_param #(.ClockFrequency(CF), .DesiredBaudRate(BR)) dut0 (
        .clk_i(clk), .rst_i(rst), .rx_i(rx[0]), .data_o(data0), .valid_o(vld[0]), .ready_i(rdy[0]),
        .frame_err_o(fe[0]), .parity_err_o(pe[0]), .overrun_o(ovr[0])
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_o(brk[0])
`endif
    );
    uart_rx_param #(.ClockFrequency(CF), .DesiredBaudRate(BR), .DataBits(7), .ParityEn(1), .ParityOdd(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .rx_i(rx[1]), .data_o(data1), .valid_o(vld[1]), .ready_i(rdy[1]),
        .frame_err_o(fe[1]), .parity_err_o(pe[1]), .overrun_o(ovr[1])
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_o(brk[1])
`endif
    );
    uart_rx_param #(.ClockFrequency(CF), .DesiredBaudRate(BR), .StopBits(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .rx_i(rx[2]), .data_o(data2), .valid_o(vld[2]), .ready_i(rdy[2]),
        .frame_err_o(fe[2]), .parity_err_o(pe[2]), .overrun_o(ovr[2])
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_o(brk[2])
`endif
    );
`ifndef UART_RX_BREAK_DETECT_EN
    assign brk = 3'b000;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bitdrive(input int idx, input logic v, input int n);
        rx[idx] = v;
        repeat (n) step();
    endtask

    task automatic send(input int idx, input logic [8:0] d, input int nbits, input bit par_en,
                        input logic pbit, input int nstop, input logic stopv);
        bitdrive(idx, 1'b0, BIT);
        for (int b = 0; b < nbits; b++) bitdrive(idx, d[b], BIT);
        if (par_en) bitdrive(idx, pbit, BIT);
        for (int s = 0; s < nstop; s++) bitdrive(idx, stopv, BIT);
        rx[idx] = 1'b1;
    endtask

    task automatic push(input int idx, input logic [8:0] d, input logic f, input logic p);
        exp_t e;
        e = '{data: d, ferr: f, perr: p};
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pops the scoreboard on every handshake and tallies pulse outputs.
    task automatic mon();
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 3; i++) begin
                    if (ovr[i]) ov_cnt[i]++;
                    if (brk[i]) brk_cnt[i]++;
                    if (vld[i] && rdy[i]) begin
                        exp_t e;
                        logic hit;
                        hit = 1'b0;
                        e   = '0;
                        case (i)
                            0:       if (q0.size() > 0) begin e = q0.pop_front(); hit = 1'b1; end
                            1:       if (q1.size() > 0) begin e = q1.pop_front(); hit = 1'b1; end
                            default: if (q2.size() > 0) begin e = q2.pop_front(); hit = 1'b1; end
                        endcase
                        checks++;
                        assert (hit) else begin
                            errors++;
                            $error("FAIL unexpected_frame dut%0d observed data=%0h expected no output", i, dat[i]);
                        end
                        if (hit) begin
                            checks++;
                            assert ({dat[i], fe[i], pe[i]} === {e.data, e.ferr, e.perr}) else begin
                                errors++;
                                $error("FAIL frame dut%0d observed data=%0h fe=%b pe=%b expected data=%0h fe=%b pe=%b",
                                       i, dat[i], fe[i], pe[i], e.data, e.ferr, e.perr);
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        logic [8:0] d;
        logic       p;
        int         n;
        rx  = 3'b111;
        rdy = 3'b111;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin ov_cnt[i] = 0; brk_cnt[i] = 0; end
        fork mon(); join_none
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), 32'(vld[i]), 0);
            chk($sformatf("rst_data%0d", i), 32'(dat[i]), 0);
            chk($sformatf("rst_flags%0d", i), 32'({fe[i], pe[i], ovr[i], brk[i]}), 0);
        end
        rst = 1'b0;
        repeat (BIT) step();

        // 8N1 basic frame
        push(0, 9'h0A5, 1'b0, 1'b0);
        send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (2 * BIT) step();

        // 7E1: wrong then correct parity bit
        d = 9'h055;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? 1'b1 : 1'b0;
            push(1, d, 1'b0, (^d[6:0]) != p);
            send(1, d, 7, 1'b1, p, 1, 1'b1);
            repeat (2 * BIT) step();
        end

        // Framing error then clean frame
        push(0, 9'h03C, 1'b1, 1'b0);
        send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0);
        repeat (BIT) step();
        push(0, 9'h081, 1'b0, 1'b0);
        send(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (2 * BIT) step();

        // Start-bit glitch of 2/16 bit is rejected
        bitdrive(0, 1'b0, BIT / 8);
        bitdrive(0, 1'b1, 2 * BIT);
        chk("glitch_no_valid", 32'(vld[0]), 0);
        push(0, 9'h012, 1'b0, 1'b0);
        send(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (2 * BIT) step();

        // Overrun while holding, then accept on the exact completion cycle
        rdy[0] = 1'b0;
        push(0, 9'h011, 1'b0, 1'b0);
        send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        send(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
        repeat (BIT) step();
        chk("hold_valid", 32'(vld[0]), 1);
        chk("hold_data", 32'(data0), 32'h11);
        chk("overrun_once", 32'(ov_cnt[0]), 1);
        push(0, 9'h033, 1'b0, 1'b0);
        fork
            send(0, 9'h033, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                n = 0;
                do begin step(); n++; end while (!dut0.done && n < 12 * BIT);
                chk("completion_seen", 32'(dut0.done), 1);
                rdy[0] = 1'b1;
            end
        join
        repeat (2 * BIT) step();
        chk("no_second_overrun", 32'(ov_cnt[0]), 1);
        chk("q0_drained", 32'(q0.size()), 0);

        // 8N2: reset in the middle of the data bits discards the frame
        bitdrive(2, 1'b0, BIT);
        bitdrive(2, 1'b1, BIT);
        bitdrive(2, 1'b1, BIT);
        bitdrive(2, 1'b0, BIT / 2);
        rst = 1'b1;
        rx[2] = 1'b1;
        step();
        rst = 1'b0;
        repeat (12 * BIT) step();
        chk("rst_midframe_no_valid", 32'(vld[2]), 0);
        push(2, 9'h05A, 1'b0, 1'b0);
        send(2, 9'h05A, 8, 1'b0, 1'b0, 2, 1'b1);
        repeat (2 * BIT) step();

        // Line held low for 12 bit times
`ifndef UART_RX_BREAK_DETECT_EN
        push(0, 9'h000, 1'b1, 1'b0);
`endif
        bitdrive(0, 1'b0, 12 * BIT);
        bitdrive(0, 1'b1, 3 * BIT);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("break_pulse", 32'(brk_cnt[0]), 1);
`else
        chk("break_no_pulse", 32'(brk_cnt[0]), 0);
`endif
        chk("break_no_overrun", 32'(ov_cnt[0]), 1);
        chk("q0_empty", 32'(q0.size()), 0);
        chk("q1_empty", 32'(q1.size()), 0);
        chk("q2_empty", 32'(q2.size()), 0);
        chk("other_overruns", 32'(ov_cnt[1] + ov_cnt[2]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
